dcache_miss_ctrl: RTL and testbench
===================================

Name: dcache_miss_ctrl

Overview:
- Memory-side counterpart of the data-cache hit/access logic: services every miss the hit path reports, and drives the memory bus.
- On a miss it writes back a dirty victim block (2 words), fetches the requested block (2 words) and installs it into the selected way.
- On halt it flushes every dirty frame to memory, then asserts flushed.
- Geometry: 2-way, 8 sets, 2-word blocks, 32-bit word-aligned addresses. Address fields: tag[31:6], index[5:3], blkoff[2], byte[1:0].

Parameters:
- SETS, 8, number of sets (index width = log2(SETS))
- WORDS, 2, words per block; fixed at 2 in this revision
- TAGW, 26, tag width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- miss  in  1  hit path reports miss on current dmemREN/dmemWEN
- halt  in  1  pipeline halted; start flush
- req_addr  in  32  address of missing access
- victim_way  in  1  LRU way of req index, from cache
- frm_valid  in  1  valid bit of frame at (sel_index, sel_way)
- frm_dirty  in  1  dirty bit of that frame
- frm_tag  in  TAGW  tag of that frame
- frm_data0, frm_data1  in  32 each  words of that frame
- sel_index  out  3  frame index being examined
- sel_way  out  1  frame way being examined
- busy  out  1  controller owns cache; hit path stalls
- inst_en  out  1  one-cycle install strobe
- inst_tag  out  TAGW  tag to write; valid=1, dirty=0 are written on install
- inst_data0, inst_data1  out  32 each  fetched words
- clr_dirty  out  1  one-cycle strobe: clear dirty of (sel_index, sel_way)
- dREN, dWEN  out  1 each  memory read/write request
- daddr  out  32  memory word address
- dstore  out  32  write data
- dload  in  32  read data
- dwait  in  1  memory busy; a transfer completes on a cycle where request is high and dwait is low
- flushed  out  1  flush complete, held until reset

Behaviour:
Reset:
- RST high at a clock edge forces IDLE and clears the flush counter and fetch buffers.
- All outputs are 0 after reset.
- RST mid-transaction drops dREN/dWEN on the next cycle; no install or clr_dirty strobe is issued.

sel_index / sel_way:
- During miss handling: req_addr[5:3] and the victim_way latched at IDLE exit.
- During flush: the flush counter {index, way}.

States:
- IDLE: busy=0.
  - halt=1 -> FL_CHK; halt has priority over miss.
  - Otherwise miss=1 -> latch addr and way. Go to WB0 if frm_valid&frm_dirty, else RD0.
- WB0: dWEN=1, daddr={frm_tag, index, 0, 00}, dstore=frm_data0. On dwait=0 -> WB1.
- WB1: as WB0 with blkoff=1 and frm_data1. On dwait=0 -> RD0.
- RD0: dREN=1, daddr={req tag, index, 0, 00}. On dwait=0 -> capture dload into buf0, go to RD1.
- RD1: as RD0 with blkoff=1. On dwait=0 -> capture buf1, go to INST.
- INST: inst_en=1 for exactly one cycle with inst_data0=buf0, inst_data1=buf1, inst_tag=req tag -> IDLE.
  - The hit path re-evaluates the next cycle and hits.
  - The requested word is never forwarded from the bus.
- FL_CHK: if frm_valid&frm_dirty -> FW0, else FL_NXT.
- FW0/FW1: write both words as in WB0/WB1 using frm_* of the flush frame. After FW1 completes, clr_dirty=1 for one cycle -> FL_NXT.
- FL_NXT: if counter = {SETS-1, 1} -> DONE; otherwise counter+1 -> FL_CHK.
  - Counter order is (idx0,w0), (idx0,w1), (idx1,w0), …
- DONE: flushed=1, busy=1, dREN=dWEN=0. Stays here until reset; halt deassertion is ignored.

Busy and handshake rules:
- busy=1 in every state except IDLE.
- busy rises the cycle after a miss is accepted.
- dREN and dWEN are never high together.
- Request signals and daddr are held stable until the completing cycle.
- The bus is released (dREN=dWEN=0) in INST, FL_CHK, FL_NXT and DONE.
- A miss arriving during flush is ignored.
- The daddr low 2 bits are always 00.

Latency:
- Clean miss with zero-wait memory: miss cycle -> RD0 -> RD1 -> INST, i.e. inst_en 3 cycles after the miss cycle.
- Each dwait-high cycle adds one cycle.
- Dirty miss adds 2 (WB0, WB1).

Test Plan:
- Clean miss: frm_valid=0, req_addr=0x0000_0108, dwait=0, dload=0xAAAA then 0xBBBB -> daddr 0x108 then 0x10C. Install exactly 3 cycles after the miss cycle with tag 0x4, data {0xAAAA, 0xBBBB}; no dWEN.
- Dirty miss: frm_dirty=1, frm_tag=0x3, index 1, data {0x11, 0x22}, req_addr=0x148 -> dWEN at 0xC8 (0x11), then 0xCC (0x22), then dREN at 0x148 and 0x14C; install; total 5 cycles with zero wait.
- Wait states: dwait high 3 cycles on each transfer -> daddr, dstore and dREN/dWEN held constant; dload captured only on the dwait-low cycle.
- Flush: dirty frames only at (2,1) and (7,0) -> exactly 4 dWEN transfers and 2 clr_dirty pulses in counter order; flushed=1 after visiting (7,1); dREN never asserted.
- Halt and miss asserted together in IDLE -> flush path taken, no fill.
- RST asserted during RD1 -> next cycle all outputs 0, state IDLE, no inst_en; a subsequent miss services normally.

Source files
------------

// File: rtl/dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_miss_ctrl
//  Description : Miss/flush engine for the 2-way data cache. Writes back a
//                dirty victim block, fetches and installs the missing block,
//                and on halt flushes every dirty frame to memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_miss_ctrl #(
   parameter int SETS  = 8,
   parameter int WORDS = 2,
   parameter int TAGW  = 26
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    miss,
   input  logic                    halt,
   input  logic [31:0]             req_addr,
   input  logic                    victim_way,
   input  logic                    frm_valid,
   input  logic                    frm_dirty,
   input  logic [TAGW-1:0]         frm_tag,
   input  logic [31:0]             frm_data0,
   input  logic [31:0]             frm_data1,
   output logic [$clog2(SETS)-1:0] sel_index,
   output logic                    sel_way,
   output logic                    busy,
   output logic                    inst_en,
   output logic [TAGW-1:0]         inst_tag,
   output logic [31:0]             inst_data0,
   output logic [31:0]             inst_data1,
   output logic                    clr_dirty,
   output logic                    dREN,
   output logic                    dWEN,
   output logic [31:0]             daddr,
   output logic [31:0]             dstore,
   input  logic [31:0]             dload,
   input  logic                    dwait,
   output logic                    flushed
);

   localparam int c_IW   = $clog2(SETS);
   localparam int c_OFFW = $clog2(WORDS);
   localparam int c_TLO  = c_IW + c_OFFW + 2;
   // Flush counter value {index, way} of the last frame to visit
   localparam logic [c_IW:0] c_FL_LAST = {c_IW'(SETS - 1), 1'b1};

   typedef enum logic [3:0] {
      S_IDLE, S_WB0, S_WB1, S_RD0, S_RD1, S_INST,
      S_FL_CHK, S_FW0, S_FW1, S_FL_CLR, S_FL_NXT, S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [c_IW-1:0]   r_idx;
   logic              r_way;
   logic [TAGW-1:0]   r_tag;
   logic [31:0]       r_buf0;
   logic [31:0]       r_buf1;
   logic [c_IW:0]     r_cnt;
   logic              w_frm_dirty;
   logic              w_unused_ok;

   assign w_frm_dirty = frm_valid & frm_dirty;
   // Byte and block-offset bits of the request never reach the bus
   assign w_unused_ok = ^req_addr[c_OFFW+1:0];

   // State register, request latch, fetch buffers and flush counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_way   <= 1'b0;
         r_tag   <= '0;
         r_buf0  <= '0;
         r_buf1  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && !halt && miss) begin
            r_idx <= req_addr[c_TLO-1:c_OFFW+2];
            r_way <= victim_way;
            r_tag <= req_addr[31:c_TLO];
         end
         if (r_state == S_RD0 && !dwait) r_buf0 <= dload;
         if (r_state == S_RD1 && !dwait) r_buf1 <= dload;
         if (r_state == S_FL_NXT && r_cnt != c_FL_LAST) r_cnt <= r_cnt + (c_IW+1)'(1);
      end
   end

   // Next-state and Moore outputs; bus requests hold until dwait drops
   always_comb begin
      w_next     = r_state;
      busy       = 1'b1;
      sel_index  = '0;
      sel_way    = 1'b0;
      inst_en    = 1'b0;
      inst_tag   = '0;
      inst_data0 = '0;
      inst_data1 = '0;
      clr_dirty  = 1'b0;
      dREN       = 1'b0;
      dWEN       = 1'b0;
      daddr      = '0;
      dstore     = '0;
      flushed    = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (halt) begin
               w_next = S_FL_CHK;
            end else if (miss) begin
               // Present the victim frame so its dirty state can be judged now
               sel_index = req_addr[c_TLO-1:c_OFFW+2];
               sel_way   = victim_way;
               w_next    = w_frm_dirty ? S_WB0 : S_RD0;
            end
         end
         S_WB0, S_WB1: begin
            sel_index = r_idx;
            sel_way   = r_way;
            dWEN      = 1'b1;
            daddr     = {frm_tag, r_idx, c_OFFW'(r_state == S_WB1), 2'b00};
            dstore    = (r_state == S_WB1) ? frm_data1 : frm_data0;
            if (!dwait) w_next = (r_state == S_WB1) ? S_RD0 : S_WB1;
         end
         S_RD0, S_RD1: begin
            sel_index = r_idx;
            sel_way   = r_way;
            dREN      = 1'b1;
            daddr     = {r_tag, r_idx, c_OFFW'(r_state == S_RD1), 2'b00};
            if (!dwait) w_next = (r_state == S_RD1) ? S_INST : S_RD1;
         end
         S_INST: begin
            sel_index  = r_idx;
            sel_way    = r_way;
            inst_en    = 1'b1;
            inst_tag   = r_tag;
            inst_data0 = r_buf0;
            inst_data1 = r_buf1;
            w_next     = S_IDLE;
         end
         S_FL_CHK: begin
            sel_index = r_cnt[c_IW:1];
            sel_way   = r_cnt[0];
            w_next    = w_frm_dirty ? S_FW0 : S_FL_NXT;
         end
         S_FW0, S_FW1: begin
            sel_index = r_cnt[c_IW:1];
            sel_way   = r_cnt[0];
            dWEN      = 1'b1;
            daddr     = {frm_tag, r_cnt[c_IW:1], c_OFFW'(r_state == S_FW1), 2'b00};
            dstore    = (r_state == S_FW1) ? frm_data1 : frm_data0;
            if (!dwait) w_next = (r_state == S_FW1) ? S_FL_CLR : S_FW1;
         end
         S_FL_CLR: begin
            sel_index = r_cnt[c_IW:1];
            sel_way   = r_cnt[0];
            clr_dirty = 1'b1;
            w_next    = S_FL_NXT;
         end
         S_FL_NXT: begin
            sel_index = r_cnt[c_IW:1];
            sel_way   = r_cnt[0];
            w_next    = (r_cnt == c_FL_LAST) ? S_DONE : S_FL_CHK;
         end
         S_DONE: begin
            sel_index = r_cnt[c_IW:1];
            sel_way   = r_cnt[0];
            flushed   = 1'b1;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_miss_ctrl
//  Description : Self-checking bench for dcache_miss_ctrl. Holds a model of
//                the cache frames and of memory, answers the bus, and compares
//                the observed transfers/installs against expected ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_miss_ctrl;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } bus_ev_t;

   typedef struct packed {
      logic [3:0]  frame;
      logic [25:0] tag;
      logic [31:0] d0;
      logic [31:0] d1;
      int          cyc;
   } inst_ev_t;

   logic        CLK = 1'b0;
   logic        RST, miss, halt, victim_way, dwait;
   logic [31:0] req_addr, dload;
   logic        frm_valid, frm_dirty;
   logic [25:0] frm_tag;
   logic [31:0] frm_data0, frm_data1;
   logic [2:0]  sel_index;
   logic        sel_way, busy, inst_en, clr_dirty, dREN, dWEN, flushed;
   logic [25:0] inst_tag;
   logic [31:0] inst_data0, inst_data1, daddr, dstore;

   // cache frame model, indexed by index*2 + way
   logic        m_valid [16];
   logic        m_dirty [16];
   logic [25:0] m_tag   [16];
   logic [31:0] m_d0    [16];
   logic [31:0] m_d1    [16];
   logic [31:0] mem_over [logic [31:0]];

   bus_ev_t  bus_q[$], exp_bus[$];
   inst_ev_t inst_q[$], exp_inst;
   int       clr_q[$], exp_clr[$];

   int checks = 0, failures = 0;
   int cyc = 0, wait_mode = 0, wcnt = 0;
   bit prev_hold = 0, rst_at_edge = 0;
   logic p_ren, p_wen;
   logic [31:0] p_addr, p_store;

   always #5 CLK = ~CLK;

   assign frm_valid = m_valid[{sel_index, sel_way}];
   assign frm_dirty = m_dirty[{sel_index, sel_way}];
   assign frm_tag   = m_tag[{sel_index, sel_way}];
   assign frm_data0 = m_d0[{sel_index, sel_way}];
   assign frm_data1 = m_d1[{sel_index, sel_way}];

   dcache_miss_ctrl dut (
      .CLK(CLK), .RST(RST), .miss(miss), .halt(halt), .req_addr(req_addr),
      .victim_way(victim_way), .frm_valid(frm_valid), .frm_dirty(frm_dirty),
      .frm_tag(frm_tag), .frm_data0(frm_data0), .frm_data1(frm_data1),
      .sel_index(sel_index), .sel_way(sel_way), .busy(busy), .inst_en(inst_en),
      .inst_tag(inst_tag), .inst_data0(inst_data0), .inst_data1(inst_data1),
      .clr_dirty(clr_dirty), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
      .dstore(dstore), .dload(dload), .dwait(dwait), .flushed(flushed)
   );

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_over.exists(a)) return mem_over[a];
      return (a * 32'd2654435761) ^ 32'h5A5A_1234;
   endfunction

   always @(posedge CLK) begin
      cyc         <= cyc + 1;
      rst_at_edge <= RST;
   end

   // Memory responder, bus monitor and cache-array side effects
   always @(negedge CLK) begin : b_resp
      bit       dw;
      bus_ev_t  e;
      inst_ev_t ie;
      checks++;
      if ((dREN & dWEN) !== 1'b0) begin
         failures++;
         $display("FAIL bus_exclusive dREN=%b dWEN=%b required not both high", dREN, dWEN);
      end
      checks++;
      if (daddr[1:0] !== 2'b00) begin
         failures++;
         $display("FAIL daddr_align got %h required low bits 00", daddr);
      end
      if (prev_hold && !rst_at_edge) begin
         checks++;
         if ({dREN, dWEN, daddr, dstore} !== {p_ren, p_wen, p_addr, p_store}) begin
            failures++;
            $display("FAIL bus_hold got ren=%b wen=%b addr=%h st=%h required ren=%b wen=%b addr=%h st=%h",
                     dREN, dWEN, daddr, dstore, p_ren, p_wen, p_addr, p_store);
         end
      end
      if (dREN || dWEN) begin
         case (wait_mode)
            0: dw = 1'b0;
            1: dw = ($urandom_range(0, 2) == 0);
            default: begin
               if (wcnt < 3) begin dw = 1'b1; wcnt++; end
               else begin dw = 1'b0; wcnt = 0; end
            end
         endcase
         dwait = dw;
         if (!dw) begin
            e.wr   = dWEN;
            e.addr = daddr;
            e.data = dWEN ? dstore : mem_rd(daddr);
            bus_q.push_back(e);
            dload = dREN ? mem_rd(daddr) : $urandom;
         end else begin
            dload = $urandom;
         end
         prev_hold = dw;
         p_ren = dREN; p_wen = dWEN; p_addr = daddr; p_store = dstore;
      end else begin
         dwait     = 1'($urandom_range(0, 1));
         dload     = $urandom;
         prev_hold = 0;
         wcnt      = 0;
      end
      if (inst_en === 1'b1) begin
         ie.frame = {sel_index, sel_way};
         ie.tag   = inst_tag;
         ie.d0    = inst_data0;
         ie.d1    = inst_data1;
         ie.cyc   = cyc;
         inst_q.push_back(ie);
         m_valid[ie.frame] = 1'b1;
         m_dirty[ie.frame] = 1'b0;
         m_tag[ie.frame]   = inst_tag;
         m_d0[ie.frame]    = inst_data0;
         m_d1[ie.frame]    = inst_data1;
      end
      if (clr_dirty === 1'b1) begin
         clr_q.push_back(int'({sel_index, sel_way}));
         m_dirty[{sel_index, sel_way}] = 1'b0;
      end
   end

   task automatic clear_model();
      for (int k = 0; k < 16; k++) begin
         m_valid[k] = 0; m_dirty[k] = 0; m_tag[k] = '0; m_d0[k] = '0; m_d1[k] = '0;
      end
      mem_over.delete();
   endtask

   task automatic do_reset();
      RST = 1; miss = 0; halt = 0; req_addr = '0; victim_way = 0;
      repeat (2) @(negedge CLK);
      RST = 0;
      bus_q.delete(); inst_q.delete(); clr_q.delete();
   endtask

   // Expected bus traffic and install for one miss, from the frame model
   task automatic model_miss(input logic [31:0] a, input logic w);
      int k; int idx; logic [31:0] base; bus_ev_t e; logic dirty;
      idx = int'(a[5:3]);
      k   = idx * 2 + int'(w);
      exp_bus.delete();
      dirty = m_valid[k] && m_dirty[k];
      if (dirty) begin
         base = (32'(m_tag[k]) << 6) + (32'(idx) << 3);
         e = '{1'b1, base, m_d0[k]};      exp_bus.push_back(e);
         e = '{1'b1, base + 4, m_d1[k]};  exp_bus.push_back(e);
      end
      base = (a >> 6 << 6) + (32'(idx) << 3);
      e = '{1'b0, base, mem_rd(base)};          exp_bus.push_back(e);
      e = '{1'b0, base + 4, mem_rd(base + 4)};  exp_bus.push_back(e);
      exp_inst.frame = 4'(k);
      exp_inst.tag   = 26'(a >> 6);
      exp_inst.d0    = mem_rd(base);
      exp_inst.d1    = mem_rd(base + 4);
      exp_inst.cyc   = dirty ? 5 : 3;
   endtask

   // Expected flush traffic: every valid dirty frame in {index,way} order
   task automatic model_flush();
      logic [31:0] base; bus_ev_t e;
      exp_bus.delete(); exp_clr.delete();
      for (int k = 0; k < 16; k++) begin
         if (m_valid[k] && m_dirty[k]) begin
            base = (32'(m_tag[k]) << 6) + (32'(k / 2) << 3);
            e = '{1'b1, base, m_d0[k]};     exp_bus.push_back(e);
            e = '{1'b1, base + 4, m_d1[k]}; exp_bus.push_back(e);
            exp_clr.push_back(k);
         end
      end
   endtask

   task automatic run_miss(input logic [31:0] a, input logic w, input int limit,
                           output int mcyc, output bit done);
      req_addr = a; victim_way = w; miss = 1; mcyc = cyc;
      @(negedge CLK);
      miss = 0; done = 0;
      for (int i = 0; i < limit; i++) begin
         if (inst_q.size() > 0 && !busy) begin done = 1; break; end
         @(negedge CLK);
      end
   endtask

   task automatic test_reset();
      clear_model();
      RST = 1; miss = 0; halt = 0; req_addr = $urandom; victim_way = 1;
      repeat (2) @(negedge CLK);
      checks++;
      if ({dREN, dWEN, daddr, dstore} !== 66'd0) begin
         failures++; $display("FAIL reset_bus got ren=%b wen=%b addr=%h st=%h required all 0", dREN, dWEN, daddr, dstore);
      end
      checks++;
      if ({inst_en, inst_tag, inst_data0, inst_data1} !== 91'd0) begin
         failures++; $display("FAIL reset_inst got en=%b tag=%h required 0", inst_en, inst_tag);
      end
      checks++;
      if ({busy, clr_dirty, flushed} !== 3'b000) begin
         failures++; $display("FAIL reset_ctrl got busy=%b clr=%b flushed=%b required 000", busy, clr_dirty, flushed);
      end
      checks++;
      if ({sel_index, sel_way} !== 4'd0) begin
         failures++; $display("FAIL reset_sel got %0d/%0d required 0/0", sel_index, sel_way);
      end
      RST = 0;
   endtask

   task automatic test_clean_miss();
      int mcyc; bit done; bus_ev_t e0, e1;
      clear_model(); do_reset(); wait_mode = 0;
      m_valid[3] = 1; m_dirty[3] = 1; m_tag[3] = 26'h77;
      mem_over[32'h108] = 32'hAAAA; mem_over[32'h10C] = 32'hBBBB;
      run_miss(32'h0000_0108, 1'b0, 40, mcyc, done);
      e0 = '{1'b0, 32'h108, 32'hAAAA}; e1 = '{1'b0, 32'h10C, 32'hBBBB};
      checks++;
      if (!done) begin failures++; $display("FAIL clean_done got no install required install"); end
      checks++;
      if (bus_q.size() != 2) begin
         failures++; $display("FAIL clean_bus_count got %0d required 2", bus_q.size());
      end else begin
         checks++;
         if (bus_q[0] !== e0 || bus_q[1] !== e1) begin
            failures++; $display("FAIL clean_bus got %h/%h %h/%h required 108/AAAA 10C/BBBB",
                                 bus_q[0].addr, bus_q[0].data, bus_q[1].addr, bus_q[1].data);
         end
      end
      if (inst_q.size() == 1) begin
         checks++;
         if ({inst_q[0].frame, inst_q[0].tag, inst_q[0].d0, inst_q[0].d1} !== {4'd2, 26'h4, 32'hAAAA, 32'hBBBB}) begin
            failures++; $display("FAIL clean_install got f=%0d tag=%h d=%h,%h required f=2 tag=4 d=AAAA,BBBB",
                                 inst_q[0].frame, inst_q[0].tag, inst_q[0].d0, inst_q[0].d1);
         end
         checks++;
         if (inst_q[0].cyc - mcyc != 3) begin
            failures++; $display("FAIL clean_latency got %0d required 3", inst_q[0].cyc - mcyc);
         end
      end
   endtask

   task automatic test_dirty_miss();
      int mcyc; bit done; bus_ev_t ex[4];
      clear_model(); do_reset(); wait_mode = 0;
      m_valid[3] = 1; m_dirty[3] = 1; m_tag[3] = 26'h3; m_d0[3] = 32'h11; m_d1[3] = 32'h22;
      ex[0] = '{1'b1, 32'hC8, 32'h11};
      ex[1] = '{1'b1, 32'hCC, 32'h22};
      ex[2] = '{1'b0, 32'h148, mem_rd(32'h148)};
      ex[3] = '{1'b0, 32'h14C, mem_rd(32'h14C)};
      run_miss(32'h0000_0148, 1'b1, 40, mcyc, done);
      checks++;
      if (!done || bus_q.size() != 4) begin
         failures++; $display("FAIL dirty_count got done=%0d transfers=%0d required 1/4", done, bus_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus_q[i] !== ex[i]) begin
               failures++; $display("FAIL dirty_bus[%0d] got wr=%b %h/%h required wr=%b %h/%h",
                                    i, bus_q[i].wr, bus_q[i].addr, bus_q[i].data, ex[i].wr, ex[i].addr, ex[i].data);
            end
         end
         checks++;
         if (inst_q[0].cyc - mcyc != 5 || inst_q[0].tag !== 26'h5 || inst_q[0].frame !== 4'd3) begin
            failures++; $display("FAIL dirty_install got lat=%0d tag=%h f=%0d required 5/5/3",
                                 inst_q[0].cyc - mcyc, inst_q[0].tag, inst_q[0].frame);
         end
      end
   endtask

   // Shared by the wait-state and randomized miss scenarios
   task automatic test_misses(input string nm, input int mode, input int n);
      int mcyc; bit done; logic [31:0] a; logic w; int k;
      clear_model(); do_reset(); wait_mode = mode;
      for (int it = 0; it < n; it++) begin
         a = $urandom & 32'hFFFF_FFFC; w = 1'($urandom_range(0, 1));
         k = int'(a[5:3]) * 2 + int'(w);
         m_valid[k] = 1'($urandom_range(0, 3) != 0); m_dirty[k] = 1'($urandom_range(0, 1));
         if (mode == 2) begin m_valid[k] = 1; m_dirty[k] = 1; end
         m_tag[k] = 26'($urandom); m_d0[k] = $urandom; m_d1[k] = $urandom;
         model_miss(a, w);
         bus_q.delete(); inst_q.delete();
         run_miss(a, w, 400, mcyc, done);
         checks++;
         if (!done || bus_q.size() != exp_bus.size() || inst_q.size() != 1) begin
            failures++; $display("FAIL %s_count it=%0d got done=%0d xfers=%0d inst=%0d required 1/%0d/1",
                                 nm, it, done, bus_q.size(), inst_q.size(), exp_bus.size());
            continue;
         end
         for (int i = 0; i < exp_bus.size(); i++) begin
            checks++;
            if (bus_q[i] !== exp_bus[i]) begin
               failures++; $display("FAIL %s_bus it=%0d[%0d] got wr=%b %h/%h required wr=%b %h/%h", nm, it, i,
                                    bus_q[i].wr, bus_q[i].addr, bus_q[i].data,
                                    exp_bus[i].wr, exp_bus[i].addr, exp_bus[i].data);
            end
         end
         checks++;
         if ({inst_q[0].frame, inst_q[0].tag, inst_q[0].d0, inst_q[0].d1} !==
             {exp_inst.frame, exp_inst.tag, exp_inst.d0, exp_inst.d1}) begin
            failures++; $display("FAIL %s_install it=%0d got f=%0d tag=%h d=%h,%h required f=%0d tag=%h d=%h,%h",
                                 nm, it, inst_q[0].frame, inst_q[0].tag, inst_q[0].d0, inst_q[0].d1,
                                 exp_inst.frame, exp_inst.tag, exp_inst.d0, exp_inst.d1);
         end
         if (mode == 2) begin
            checks++;
            if (inst_q[0].cyc - mcyc != exp_inst.cyc + 12) begin
               failures++; $display("FAIL %s_latency got %0d required %0d", nm, inst_q[0].cyc - mcyc, exp_inst.cyc + 12);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int mcyc; bit done; bit found;
      clear_model(); do_reset(); wait_mode = 0;
      req_addr = 32'h0000_2A50; victim_way = 0; miss = 1;
      @(negedge CLK); miss = 0; found = 0;
      for (int i = 0; i < 10; i++) begin
         if (dREN && daddr[2]) begin found = 1; break; end
         @(negedge CLK);
      end
      inst_q.delete();
      RST = 1;
      @(negedge CLK);
      checks++;
      if (!found || {busy, dREN, dWEN, inst_en, clr_dirty, flushed, daddr} !== 38'd0) begin
         failures++; $display("FAIL rst_mid got found=%0d busy=%b ren=%b wen=%b inst=%b addr=%h required RD1 seen, all 0",
                              found, busy, dREN, dWEN, inst_en, daddr);
      end
      RST = 0;
      repeat (4) @(negedge CLK);
      checks++;
      if (inst_q.size() != 0 || busy !== 1'b0) begin
         failures++; $display("FAIL rst_mid_quiet got inst=%0d busy=%b required 0/0", inst_q.size(), busy);
      end
      model_miss(32'h0000_3384, 1'b1);
      bus_q.delete(); inst_q.delete();
      run_miss(32'h0000_3384, 1'b1, 40, mcyc, done);
      checks++;
      if (!done || inst_q.size() != 1) begin
         failures++; $display("FAIL rst_mid_after got done=%0d inst=%0d required 1/1", done, inst_q.size());
      end else begin
         checks++;
         if (inst_q[0].d0 !== exp_inst.d0 || inst_q[0].d1 !== exp_inst.d1 || inst_q[0].cyc - mcyc != 3) begin
            failures++; $display("FAIL rst_mid_install got %h,%h lat=%0d required %h,%h lat=3",
                                 inst_q[0].d0, inst_q[0].d1, inst_q[0].cyc - mcyc, exp_inst.d0, exp_inst.d1);
         end
      end
   endtask

   task automatic test_flush(input string nm, input bit with_miss, input int mode);
      bit done; int nbus;
      clear_model(); do_reset(); wait_mode = mode;
      for (int k = 0; k < 16; k++) begin
         m_valid[k] = 1; m_tag[k] = 26'($urandom); m_d0[k] = $urandom; m_d1[k] = $urandom;
         m_dirty[k] = with_miss ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (!with_miss) begin m_dirty[5] = 1; m_dirty[14] = 1; end
      else m_dirty[6] = 1;
      model_flush();
      halt = 1; miss = with_miss; req_addr = 32'h0000_0018; victim_way = 0;
      done = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge CLK);
         if (flushed === 1'b1) begin done = 1; break; end
      end
      checks++;
      if (!done || bus_q.size() != exp_bus.size() || clr_q.size() != exp_clr.size()) begin
         failures++; $display("FAIL %s_count got done=%0d xfers=%0d clrs=%0d required 1/%0d/%0d",
                              nm, done, bus_q.size(), clr_q.size(), exp_bus.size(), exp_clr.size());
      end else begin
         for (int i = 0; i < exp_bus.size(); i++) begin
            checks++;
            if (bus_q[i] !== exp_bus[i]) begin
               failures++; $display("FAIL %s_bus[%0d] got wr=%b %h/%h required wr=%b %h/%h", nm, i,
                                    bus_q[i].wr, bus_q[i].addr, bus_q[i].data,
                                    exp_bus[i].wr, exp_bus[i].addr, exp_bus[i].data);
            end
         end
         for (int i = 0; i < exp_clr.size(); i++) begin
            checks++;
            if (clr_q[i] != exp_clr[i]) begin
               failures++; $display("FAIL %s_clr[%0d] got %0d required %0d", nm, i, clr_q[i], exp_clr[i]);
            end
         end
      end
      nbus = bus_q.size();
      halt = 0; miss = 1; req_addr = 32'h0000_0240;
      repeat (5) @(negedge CLK);
      miss = 0;
      checks++;
      if (flushed !== 1'b1 || busy !== 1'b1 || bus_q.size() != nbus || inst_q.size() != 0) begin
         failures++; $display("FAIL %s_done_hold got flushed=%b busy=%b xfers=%0d inst=%0d required 1/1/%0d/0",
                              nm, flushed, busy, bus_q.size(), inst_q.size(), nbus);
      end
   endtask

   initial begin
      RST = 1; miss = 0; halt = 0; req_addr = '0; victim_way = 0; dwait = 0; dload = '0;
      clear_model();
      test_reset();
      test_clean_miss();
      test_dirty_miss();
      test_misses("waits", 2, 3);
      test_misses("rand", 1, 24);
      test_misses("b2b", 0, 8);
      test_reset_mid();
      test_flush("flush", 1'b0, 0);
      test_flush("halt_miss", 1'b1, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      failures++;
      $display("FAIL watchdog got timeout required test completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
